// File: rtl/demand_scheduler.sv
// -----------------------------------------------------------------------------
// demand_scheduler
//
// Front-end controller for the intersection light sequencer.
//   * Synchronises and debounces the three vehicle sensors and three
//     pedestrian pushbuttons, and latches pedestrian requests until served.
//   * Runs the millisecond chronometer used for phase timing.
//   * At each signal-cycle boundary (cycle_start) picks the timing table
//     A/B/C/D, so the table never changes in the middle of a cycle.
//
// Ports:
//   CLK             in   system clock (10 kHz)
//   reset_general   in   asynchronous active-low reset
//   enable_general  in   run enable
//   SNN, SNS, STH   in   raw vehicle sensors
//   PNN, PNS, PTH   in   raw pedestrian pushbuttons
//   reset_chrono    in   synchronous chronometer clear
//   cycle_start     in   one-CLK pulse on entry to phase 1
//   ped_served_N    in   Norton pedestrian phase given (clears ped_req_N)
//   ped_served_TH   in   Thevenin pedestrian phases given (clears ped_req_TH)
//   ms              out  milliseconds since last reset_chrono (saturating)
//   tabla           out  committed table A=00 B=01 C=10 D=11
//   tabla_valid     out  a table has been committed since enable
//   ped_req_N       out  latched Norton pedestrian request
//   ped_req_TH      out  latched Thevenin pedestrian request
//   sensors_db      out  debounced {SNN, SNS, STH}
// -----------------------------------------------------------------------------
module demand_scheduler #(
  parameter int unsigned TICKS_PER_MS  = 32'd10,
  parameter int unsigned DEBOUNCE_MS   = 32'd20,
  parameter int unsigned STARVE_CYCLES = 32'd3
) (
  input  logic        CLK,
  input  logic        reset_general,
  input  logic        enable_general,
  input  logic        SNN,
  input  logic        SNS,
  input  logic        STH,
  input  logic        PNN,
  input  logic        PNS,
  input  logic        PTH,
  input  logic        reset_chrono,
  input  logic        cycle_start,
  input  logic        ped_served_N,
  input  logic        ped_served_TH,
  output logic [31:0] ms,
  output logic [1:0]  tabla,
  output logic        tabla_valid,
  output logic        ped_req_N,
  output logic        ped_req_TH,
  output logic [2:0]  sensors_db
);

  // Debounce window in CLK cycles and counter widths.
  localparam int unsigned   DB_LIMIT   = DEBOUNCE_MS * TICKS_PER_MS;
  localparam int unsigned   CW         = $clog2(DB_LIMIT + 32'd1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DB_LIMIT - 32'd1);
  localparam int unsigned   PW         = (TICKS_PER_MS > 32'd1) ? $clog2(TICKS_PER_MS) : 32'd1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MS - 32'd1);
  localparam int unsigned   SW         = $clog2(STARVE_CYCLES + 32'd1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_CYCLES);

  // Bit positions inside the conditioned input vector. The low three bits
  // line up with sensors_db = {SNN, SNS, STH}.
  localparam int IDX_STH = 0;
  localparam int IDX_SNS = 1;
  localparam int IDX_SNN = 2;
  localparam int IDX_PTH = 3;
  localparam int IDX_PNS = 4;
  localparam int IDX_PNN = 5;

  localparam logic [1:0] TAB_A = 2'b00;
  localparam logic [1:0] TAB_B = 2'b01;
  localparam logic [1:0] TAB_C = 2'b10;
  localparam logic [1:0] TAB_D = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------------
  logic [5:0]    raw_s;
  logic [5:0]    sync1_q, sync1_d;
  logic [5:0]    sync2_q, sync2_d;
  logic [5:0]    db_q, db_d;
  logic [5:0]    rise_s;
  logic [CW-1:0] db_cnt_q [6];
  logic [CW-1:0] db_cnt_d [6];

  assign raw_s = {PNN, PNS, PTH, SNN, SNS, STH};

  // Two-flop synchroniser and per-input debounce counters; a debounced bit
  // only flips after DB_LIMIT consecutive cycles of disagreement.
  always_comb begin
    sync1_d = raw_s;
    sync2_d = sync1_q;
    db_d    = db_q;
    rise_s  = 6'b000000;
    for (int i = 0; i < 6; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] == db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_d[i]     = ~db_q[i];
        db_cnt_d[i] = '0;
        // A flip from 0 is the debounced rising edge used by the latches.
        rise_s[i]   = ~db_q[i];
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + CW'(32'd1);
      end
    end
  end

  // Conditioning registers; they run independently of enable_general.
  always_ff @(posedge CLK or negedge reset_general) begin
    if (!reset_general) begin
      sync1_q <= 6'b000000;
      sync2_q <= 6'b000000;
      db_q    <= 6'b000000;
      for (int i = 0; i < 6; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      db_q    <= db_d;
      for (int i = 0; i < 6; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Chronometer
  // ---------------------------------------------------------------------------
  logic [PW-1:0] presc_q, presc_d;
  logic [31:0]   ms_q, ms_d;

  // Prescaler and saturating millisecond counter; reset_chrono beats a tick.
  always_comb begin
    presc_d = presc_q;
    ms_d    = ms_q;
    if (reset_chrono) begin
      presc_d = '0;
      ms_d    = 32'd0;
    end else if (enable_general) begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        if (ms_q != 32'hFFFF_FFFF) begin
          ms_d = ms_q + 32'd1;
        end else begin
          ms_d = ms_q;
        end
      end else begin
        presc_d = presc_q + PW'(32'd1);
        ms_d    = ms_q;
      end
    end else begin
      presc_d = presc_q;
      ms_d    = ms_q;
    end
  end

  // Chronometer registers.
  always_ff @(posedge CLK or negedge reset_general) begin
    if (!reset_general) begin
      presc_q <= '0;
      ms_q    <= 32'd0;
    end else begin
      presc_q <= presc_d;
      ms_q    <= ms_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Pedestrian request latches
  // ---------------------------------------------------------------------------
  logic set_n_s, set_th_s;
  logic ped_req_n_q, ped_req_n_d;
  logic ped_req_th_q, ped_req_th_d;

  assign set_n_s  = rise_s[IDX_PNN] | rise_s[IDX_PNS];
  assign set_th_s = rise_s[IDX_PTH];

  // Set/clear latches; a new press outranks a serve in the same cycle and
  // both latches freeze while the block is disabled.
  always_comb begin
    ped_req_n_d  = ped_req_n_q;
    ped_req_th_d = ped_req_th_q;
    if (enable_general) begin
      if (set_n_s) begin
        ped_req_n_d = 1'b1;
      end else if (ped_served_N) begin
        ped_req_n_d = 1'b0;
      end else begin
        ped_req_n_d = ped_req_n_q;
      end
      if (set_th_s) begin
        ped_req_th_d = 1'b1;
      end else if (ped_served_TH) begin
        ped_req_th_d = 1'b0;
      end else begin
        ped_req_th_d = ped_req_th_q;
      end
    end else begin
      ped_req_n_d  = ped_req_n_q;
      ped_req_th_d = ped_req_th_q;
    end
  end

  // Pedestrian latch registers.
  always_ff @(posedge CLK or negedge reset_general) begin
    if (!reset_general) begin
      ped_req_n_q  <= 1'b0;
      ped_req_th_q <= 1'b0;
    end else begin
      ped_req_n_q  <= ped_req_n_d;
      ped_req_th_q <= ped_req_th_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and table commit
  // ---------------------------------------------------------------------------
  state_e        state_q, state_d;
  logic          commit_en_s;
  logic [1:0]    tabla_sel_s;
  logic [1:0]    tabla_q, tabla_d;
  logic          tabla_valid_q, tabla_valid_d;
  logic [SW-1:0] starve_q, starve_d;

  // FSM state register.
  always_ff @(posedge CLK or negedge reset_general) begin
    if (!reset_general) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; COMMIT lasts exactly one cycle so a cycle_start seen
  // there is dropped.
  always_comb begin
    state_d = state_q;
    if (!enable_general) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   state_d = S_ARMED;
        S_ARMED: begin
          if (cycle_start) begin
            state_d = S_COMMIT;
          end else begin
            state_d = S_ARMED;
          end
        end
        S_COMMIT: state_d = S_ARMED;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs: commit strobe and the table chosen from the values held
  // during the COMMIT cycle.
  always_comb begin
    commit_en_s = (state_q == S_COMMIT) && enable_general;
    tabla_sel_s = TAB_A;
    if (ped_req_n_q || ped_req_th_q) begin
      tabla_sel_s = TAB_A;
    end else if (starve_q == STARVE_MAX) begin
      tabla_sel_s = TAB_A;
    end else begin
      case (db_q[IDX_SNN:IDX_STH])
        3'b001:  tabla_sel_s = TAB_B;
        3'b100:  tabla_sel_s = TAB_C;
        3'b010:  tabla_sel_s = TAB_D;
        default: tabla_sel_s = TAB_A;
      endcase
    end
  end

  // Commit datapath: table, valid flag and starvation counter.
  always_comb begin
    tabla_d       = tabla_q;
    tabla_valid_d = tabla_valid_q;
    starve_d      = starve_q;
    if (!enable_general) begin
      tabla_valid_d = 1'b0;
    end else if (commit_en_s) begin
      tabla_d       = tabla_sel_s;
      tabla_valid_d = 1'b1;
      if (tabla_sel_s == TAB_A) begin
        starve_d = '0;
      end else if (starve_q != STARVE_MAX) begin
        starve_d = starve_q + SW'(32'd1);
      end else begin
        starve_d = starve_q;
      end
    end else begin
      tabla_d       = tabla_q;
      tabla_valid_d = tabla_valid_q;
    end
  end

  // Commit registers.
  always_ff @(posedge CLK or negedge reset_general) begin
    if (!reset_general) begin
      tabla_q       <= TAB_A;
      tabla_valid_q <= 1'b0;
      starve_q      <= '0;
    end else begin
      tabla_q       <= tabla_d;
      tabla_valid_q <= tabla_valid_d;
      starve_q      <= starve_d;
    end
  end

  assign ms          = ms_q;
  assign tabla       = tabla_q;
  assign tabla_valid = tabla_valid_q;
  assign ped_req_N   = ped_req_n_q;
  assign ped_req_TH  = ped_req_th_q;
  assign sensors_db  = db_q[IDX_SNN:IDX_STH];

endmodule

// File: tb/tb_demand_scheduler.sv
// -----------------------------------------------------------------------------
// tb_demand_scheduler
//
// Self-checking bench for demand_scheduler: directed scenarios followed by a
// randomized run, every output compared each cycle against a behavioural
// model that works in elapsed ticks, run lengths and table-selection rules.
// -----------------------------------------------------------------------------
module tb_demand_scheduler;

  localparam int TICKS    = 10;
  localparam int DB_TICKS = 200;
  localparam int STARVE   = 3;
  localparam int ST_IDLE   = 0;
  localparam int ST_ARMED  = 1;
  localparam int ST_COMMIT = 2;

  logic        CLK = 1'b0;
  logic        reset_general = 1'b0;
  logic        enable_general = 1'b0;
  logic        SNN = 1'b0, SNS = 1'b0, STH = 1'b0;
  logic        PNN = 1'b0, PNS = 1'b0, PTH = 1'b0;
  logic        reset_chrono = 1'b0;
  logic        cycle_start = 1'b0;
  logic        ped_served_N = 1'b0;
  logic        ped_served_TH = 1'b0;
  logic [31:0] ms;
  logic [1:0]  tabla;
  logic        tabla_valid;
  logic        ped_req_N;
  logic        ped_req_TH;
  logic [2:0]  sensors_db;

  int checks = 0;
  int errors = 0;

  demand_scheduler dut (
    .CLK            (CLK),
    .reset_general  (reset_general),
    .enable_general (enable_general),
    .SNN            (SNN),
    .SNS            (SNS),
    .STH            (STH),
    .PNN            (PNN),
    .PNS            (PNS),
    .PTH            (PTH),
    .reset_chrono   (reset_chrono),
    .cycle_start    (cycle_start),
    .ped_served_N   (ped_served_N),
    .ped_served_TH  (ped_served_TH),
    .ms             (ms),
    .tabla          (tabla),
    .tabla_valid    (tabla_valid),
    .ped_req_N      (ped_req_N),
    .ped_req_TH     (ped_req_TH),
    .sensors_db     (sensors_db)
  );

  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  bit [5:0] m_s1, m_s2, m_db;   // index 0 STH,1 SNS,2 SNN,3 PTH,4 PNS,5 PNN
  int       m_run [6];          // consecutive cycles synced value != debounced
  longint   m_ticks;            // enabled CLK cycles since last chrono clear
  int       m_state;
  bit [1:0] m_tabla;
  bit       m_valid;
  int       m_starve;
  bit       m_pn, m_pth;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 6'd0; m_s2 = 6'd0; m_db = 6'd0;
    for (int i = 0; i < 6; i++) m_run[i] = 0;
    m_ticks = 0; m_state = ST_IDLE; m_tabla = 2'd0; m_valid = 1'b0;
    m_starve = 0; m_pn = 1'b0; m_pth = 1'b0;
  endtask

  function automatic bit [1:0] pick_table(input bit [2:0] s, input bit ped, input int starve);
    if (ped) return 2'd0;
    if (starve == STARVE) return 2'd0;
    if ($countones(s) != 1) return 2'd0;
    if (s[0]) return 2'd1;   // STH
    if (s[2]) return 2'd2;   // SNN
    return 2'd3;             // SNS
  endfunction

  // Advance the model by one active clock edge using the current inputs.
  task automatic model_edge();
    bit [5:0] raw, old_db;
    bit       old_pn, old_pth;
    if (!reset_general) begin
      model_reset();
      return;
    end
    raw     = {PNN, PNS, PTH, SNN, SNS, STH};
    old_db  = m_db;
    old_pn  = m_pn;
    old_pth = m_pth;
    for (int i = 0; i < 6; i++) begin
      if (m_s2[i] != m_db[i]) begin
        m_run[i]++;
        if (m_run[i] == DB_TICKS) begin
          m_db[i]  = ~m_db[i];
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
    if (reset_chrono) m_ticks = 0;
    else if (enable_general) m_ticks++;
    if (enable_general) begin
      if ((m_db[5] && !old_db[5]) || (m_db[4] && !old_db[4])) m_pn = 1'b1;
      else if (ped_served_N) m_pn = 1'b0;
      if (m_db[3] && !old_db[3]) m_pth = 1'b1;
      else if (ped_served_TH) m_pth = 1'b0;
    end
    if (!enable_general) begin
      m_valid = 1'b0;
    end else if (m_state == ST_COMMIT) begin
      m_tabla = pick_table(old_db[2:0], old_pn || old_pth, m_starve);
      m_valid = 1'b1;
      if (m_tabla == 2'd0) m_starve = 0;
      else if (m_starve < STARVE) m_starve++;
    end
    if (!enable_general) m_state = ST_IDLE;
    else begin
      case (m_state)
        ST_IDLE:   m_state = ST_ARMED;
        ST_ARMED:  m_state = cycle_start ? ST_COMMIT : ST_ARMED;
        ST_COMMIT: m_state = ST_ARMED;
        default:   m_state = ST_IDLE;
      endcase
    end
  endtask

  task automatic check_all();
    check_val("ms", ms, 32'(m_ticks / TICKS));
    check_val("tabla", {30'd0, tabla}, {30'd0, m_tabla});
    check_val("tabla_valid", {31'd0, tabla_valid}, {31'd0, m_valid});
    check_val("ped_req_N", {31'd0, ped_req_N}, {31'd0, m_pn});
    check_val("ped_req_TH", {31'd0, ped_req_TH}, {31'd0, m_pth});
    check_val("sensors_db", {29'd0, sensors_db}, {29'd0, m_db[2:0]});
  endtask

  // One clock: model and DUT advance on the same edge, compare 1 time unit later.
  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic pulse_cycle_start();
    cycle_start = 1'b1;
    step();
    cycle_start = 1'b0;
  endtask

  // Assert reset between clock edges and check outputs clear without a clock.
  task automatic async_reset();
    #2;
    reset_general = 1'b0;
    #1;
    model_reset();
    check_val("rst_ms", ms, 32'd0);
    check_val("rst_tabla", {30'd0, tabla}, 32'd0);
    check_val("rst_valid", {31'd0, tabla_valid}, 32'd0);
    check_val("rst_ped", {30'd0, ped_req_N, ped_req_TH}, 32'd0);
    repeat (3) step();
    reset_general = 1'b1;
  endtask

  int       n;
  bit [1:0] starve_exp [5];

  initial begin
    model_reset();
    repeat (3) step();
    reset_general = 1'b1;
    check_all();

    // Chronometer reaches 500 ms, then an asynchronous reset mid-count.
    enable_general = 1'b1;
    repeat (5000) step();
    check_val("ms_500", ms, 32'd500);
    async_reset();

    // Chronometer: 10000 cycles, clear, count again, then freeze.
    repeat (10000) step();
    check_val("ms_1000", ms, 32'd1000);
    reset_chrono = 1'b1;
    step();
    reset_chrono = 1'b0;
    check_val("ms_clear", ms, 32'd0);
    repeat (55) step();
    check_val("ms_55", ms, 32'd5);
    enable_general = 1'b0;
    repeat (100) step();
    check_val("ms_frozen", ms, 32'd5);
    enable_general = 1'b1;
    repeat (3) step();

    // Debounce: 150-cycle glitch rejected, steady level accepted after 202 edges.
    STH = 1'b1;
    repeat (150) step();
    STH = 1'b0;
    repeat (20) step();
    check_val("db_glitch", {29'd0, sensors_db}, 32'd0);
    STH = 1'b1;
    n = 0;
    while (sensors_db[0] == 1'b0 && n < 400) begin
      step();
      n++;
    end
    check_val("db_latency", n, 32'd202);

    // STH alone selects B two clocks after cycle_start.
    pulse_cycle_start();
    check_val("tabla_1clk", {30'd0, tabla}, 32'd0);
    step();
    check_val("tabla_B", {30'd0, tabla}, 32'd1);
    check_val("valid_B", {31'd0, tabla_valid}, 32'd1);

    // Sensors change without cycle_start: table holds; then two sensors -> A.
    STH = 1'b0; SNN = 1'b1; SNS = 1'b1;
    repeat (210) step();
    check_val("db_two", {29'd0, sensors_db}, 32'd6);
    check_val("tabla_hold", {30'd0, tabla}, 32'd1);
    pulse_cycle_start();
    step();
    check_val("tabla_two_A", {30'd0, tabla}, 32'd0);

    // Starvation: SNN alone over five boundaries -> C C C A C.
    SNS = 1'b0;
    repeat (210) step();
    check_val("db_snn", {29'd0, sensors_db}, 32'd4);
    starve_exp = '{2'd2, 2'd2, 2'd2, 2'd0, 2'd2};
    for (int k = 0; k < 5; k++) begin
      pulse_cycle_start();
      step();
      check_val("tabla_starve", {30'd0, tabla}, {30'd0, starve_exp[k]});
      repeat (5) step();
    end

    // Pedestrian request forces A despite STH; serve clears; set beats serve.
    SNN = 1'b0; STH = 1'b1; PTH = 1'b1;
    repeat (210) step();
    check_val("ped_th_set", {31'd0, ped_req_TH}, 32'd1);
    check_val("db_sth", {29'd0, sensors_db}, 32'd1);
    pulse_cycle_start();
    step();
    check_val("tabla_ped_A", {30'd0, tabla}, 32'd0);
    ped_served_TH = 1'b1;
    step();
    ped_served_TH = 1'b0;
    check_val("ped_th_served", {31'd0, ped_req_TH}, 32'd0);
    PTH = 1'b0;
    repeat (210) step();
    PTH = 1'b1;
    repeat (201) step();
    ped_served_TH = 1'b1;
    step();
    ped_served_TH = 1'b0;
    check_val("ped_set_wins", {31'd0, ped_req_TH}, 32'd1);

    // Randomized run against the model.
    for (int c = 0; c < 8000; c++) begin
      if ($urandom_range(0, 149) == 0) STH = ~STH;
      if ($urandom_range(0, 149) == 0) SNS = ~SNS;
      if ($urandom_range(0, 149) == 0) SNN = ~SNN;
      if ($urandom_range(0, 149) == 0) PTH = ~PTH;
      if ($urandom_range(0, 149) == 0) PNS = ~PNS;
      if ($urandom_range(0, 149) == 0) PNN = ~PNN;
      cycle_start   = ($urandom_range(0, 24) == 0);
      ped_served_N  = ($urandom_range(0, 59) == 0);
      ped_served_TH = ($urandom_range(0, 59) == 0);
      reset_chrono  = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 399) == 0) enable_general = ~enable_general;
      step();
    end
    cycle_start = 1'b0; ped_served_N = 1'b0; ped_served_TH = 1'b0; reset_chrono = 1'b0;
    step();
    async_reset();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
